// File: rtl/imem_program_loader.sv
// Instruction memory program loader: assembles a framed, checksummed
// big-endian byte stream into words and holds the CPU until it is loaded.
module imem_program_loader #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] words_loaded
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    logic [2:0]        state;
    logic [7:0]        len_hi;
    logic [ADDR_W-1:0] n_words;
    logic [1:0]        byte_cnt;
    logic [DATA_W-1:0] asm_word;
    logic [7:0]        chk;
    logic              accept;
    logic              can_start;
    logic [15:0]       len_val;
    logic [DATA_W-1:0] word_next;

    // Status outputs decode the state register only, never in_valid.
    assign busy      = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                       (state == S_DATA)   || (state == S_CHECK);
    assign in_ready  = busy;
    assign done      = (state == S_DONE);
    assign cpu_run   = (state == S_DONE);
    assign error     = (state == S_ERROR);
    assign can_start = (state == S_IDLE) || (state == S_DONE) ||
                       (state == S_ERROR);

    assign accept    = in_valid && in_ready;
    assign len_val   = {len_hi, in_data};
    assign word_next = {asm_word[DATA_W-9:0], in_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            len_hi       <= '0;
            n_words      <= '0;
            byte_cnt     <= '0;
            asm_word     <= '0;
            chk          <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;
            if (accept) begin
                chk <= chk ^ in_data;
            end
            unique case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state        <= S_LEN_HI;
                        words_loaded <= '0;
                        chk          <= '0;
                        byte_cnt     <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len_hi <= in_data;
                        state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        n_words <= ADDR_W'(len_val);
                        if (len_val == 16'd0 || 32'(len_val) > MAX_WORDS) begin
                            state <= S_ERROR;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        asm_word <= word_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_addr    <= words_loaded;
                            imem_wdata   <= word_next;
                            words_loaded <= words_loaded + 1'b1;
                            if (words_loaded + 1'b1 == n_words) begin
                                state <= S_CHECK;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        state <= (in_data == chk) ? S_DONE : S_ERROR;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
